// File: rtl/mem_wb_pipe_elastic.sv
// Elastic MEM->WB pipeline stage: LANES writeback bundles per beat, two-entry
// (main + skid) buffer so in_ready never depends combinationally on out_ready.
module mem_wb_pipe_elastic #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int REGW  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_kill,
  input  logic [LANES-1:0]        in_RegWrite,
  input  logic [2*LANES-1:0]      in_ResultSrc,
  input  logic [XLEN*LANES-1:0]   in_ALUResult,
  input  logic [XLEN*LANES-1:0]   in_ReadData,
  input  logic [XLEN*LANES-1:0]   in_PCPlus4,
  input  logic [REGW*LANES-1:0]   in_Rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_RegWrite,
  output logic [2*LANES-1:0]      out_ResultSrc,
  output logic [XLEN*LANES-1:0]   out_ALUResult,
  output logic [XLEN*LANES-1:0]   out_ReadData,
  output logic [XLEN*LANES-1:0]   out_PCPlus4,
  output logic [REGW*LANES-1:0]   out_Rd,
  output logic [1:0]              count
);

  typedef struct packed {
    logic [LANES-1:0]      rw;
    logic [2*LANES-1:0]    src;
    logic [XLEN*LANES-1:0] alu;
    logic [XLEN*LANES-1:0] rdata;
    logic [XLEN*LANES-1:0] pc4;
    logic [REGW*LANES-1:0] rd;
  } beat_t;

  beat_t            in_beat;
  beat_t            main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic             accept, drain;
  logic [LANES-1:0] cap_rw;

  // Killed lanes and writes to x0 are turned into no-ops at capture time.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign cap_rw[gi] = in_RegWrite[gi] & ~in_kill[gi] & (in_Rd[gi*REGW +: REGW] != '0);
  end

  assign in_beat.rw    = cap_rw;
  assign in_beat.src   = in_ResultSrc;
  assign in_beat.alu   = in_ALUResult;
  assign in_beat.rdata = in_ReadData;
  assign in_beat.pc4   = in_PCPlus4;
  assign in_beat.rd    = in_Rd;

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    case ({main_valid_q, skid_valid_q})
      2'b00: begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_d       = in_beat;
        end
      end
      2'b10: begin
        if (accept && drain) begin
          main_d = in_beat;
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_d       = in_beat;
        end else if (drain) begin
          main_valid_d = 1'b0;
        end
      end
      2'b11: begin
        if (drain) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_d       = main_q;
      skid_d       = skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign out_RegWrite  = main_q.rw & {LANES{main_valid_q}};
  assign out_ResultSrc = main_q.src;
  assign out_ALUResult = main_q.alu;
  assign out_ReadData  = main_q.rdata;
  assign out_PCPlus4   = main_q.pc4;
  assign out_Rd        = main_q.rd;
  assign count         = {main_valid_q & skid_valid_q, main_valid_q ^ skid_valid_q};

endmodule

// File: tb/tb_mem_wb_pipe_elastic.sv
// Directed bench for mem_wb_pipe_elastic: default 2x32 build plus a 4x64 build.
module tb_mem_wb_pipe_elastic;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // LANES=2, XLEN=32 instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [1:0]  in_kill = '0, in_RegWrite = '0, out_RegWrite, count;
  logic [3:0]  in_ResultSrc = '0, out_ResultSrc;
  logic [63:0] in_ALUResult = '0, in_ReadData = '0, in_PCPlus4 = '0;
  logic [63:0] out_ALUResult, out_ReadData, out_PCPlus4;
  logic [9:0]  in_Rd = '0, out_Rd;

  mem_wb_pipe_elastic u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kill(in_kill),
    .in_RegWrite(in_RegWrite), .in_ResultSrc(in_ResultSrc),
    .in_ALUResult(in_ALUResult), .in_ReadData(in_ReadData),
    .in_PCPlus4(in_PCPlus4), .in_Rd(in_Rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_RegWrite(out_RegWrite), .out_ResultSrc(out_ResultSrc),
    .out_ALUResult(out_ALUResult), .out_ReadData(out_ReadData),
    .out_PCPlus4(out_PCPlus4), .out_Rd(out_Rd), .count(count)
  );

  // LANES=4, XLEN=64 instance
  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [3:0]   in_kill4 = '0, in_RegWrite4 = '0, out_RegWrite4;
  logic [7:0]   in_ResultSrc4 = '0, out_ResultSrc4;
  logic [255:0] in_ALUResult4 = '0, in_ReadData4 = '0, in_PCPlus44 = '0;
  logic [255:0] out_ALUResult4, out_ReadData4, out_PCPlus44;
  logic [19:0]  in_Rd4 = '0, out_Rd4;
  logic [1:0]   count4;

  mem_wb_pipe_elastic #(.LANES(4), .XLEN(64), .REGW(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_kill(in_kill4),
    .in_RegWrite(in_RegWrite4), .in_ResultSrc(in_ResultSrc4),
    .in_ALUResult(in_ALUResult4), .in_ReadData(in_ReadData4),
    .in_PCPlus4(in_PCPlus44), .in_Rd(in_Rd4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_RegWrite(out_RegWrite4), .out_ResultSrc(out_ResultSrc4),
    .out_ALUResult(out_ALUResult4), .out_ReadData(out_ReadData4),
    .out_PCPlus4(out_PCPlus44), .out_Rd(out_Rd4), .count(count4)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] rw,
                      input logic [1:0] kill, input logic [4:0] r0, input logic [4:0] r1);
    in_valid     = 1'b1;
    in_ALUResult = {a1, a0};
    in_ReadData  = {~a1, ~a0};
    in_PCPlus4   = {a1 + 32'd4, a0 + 32'd4};
    in_Rd        = {r1, r0};
    in_RegWrite  = rw;
    in_kill      = kill;
    in_ResultSrc = 4'b1001;
  endtask

  // Main empty with skid full ({0,1}) must never be observed.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(out_valid === 1'b0 && count === 2'd1)) else begin
        errors++;
        $error("FAIL state01: observed out_valid=%b count=%0d expected not skid-only", out_valid, count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", count, 2'd0);
    chk("rst_alu", out_ALUResult, 64'h0);
    chk("rst_rd", out_Rd, 10'h0);
    chk("rst_pc4", out_PCPlus4, 64'h0);
    chk("rst_rw", out_RegWrite, 2'b00);
    #1 rst_n = 1'b1;

    // Streaming at one beat per cycle
    out_ready = 1'b1;
    beat(32'h10, 32'h11, 2'b11, 2'b00, 5'd1, 5'd2);
    tick();
    chk("s1_valid", out_valid, 1'b1);
    chk("s1_alu0", out_ALUResult[31:0], 32'h10);
    chk("s1_count", count, 2'd1);
    chk("s1_rw", out_RegWrite, 2'b11);
    chk("s1_rdata0", out_ReadData[31:0], 32'hFFFF_FFEF);
    chk("s1_pc4_1", out_PCPlus4[63:32], 32'h15);
    chk("s1_src", out_ResultSrc, 4'b1001);
    beat(32'h20, 32'h21, 2'b11, 2'b00, 5'd1, 5'd2);
    tick();
    chk("s2_alu0", out_ALUResult[31:0], 32'h20);
    chk("s2_count", count, 2'd1);
    chk("s2_in_ready", in_ready, 1'b1);
    beat(32'h30, 32'h31, 2'b11, 2'b00, 5'd1, 5'd2);
    tick();
    chk("s3_alu0", out_ALUResult[31:0], 32'h30);
    chk("s3_count", count, 2'd1);
    in_valid = 1'b0;
    tick();
    chk("s4_valid", out_valid, 1'b0);
    chk("s4_count", count, 2'd0);
    chk("s4_rw_gated", out_RegWrite, 2'b00);

    // Backpressure: A, B absorbed, C held
    out_ready = 1'b0;
    beat(32'hA, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    chk("bp_a_count", count, 2'd1);
    chk("bp_a_ready", in_ready, 1'b1);
    beat(32'hB, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    chk("bp_b_count", count, 2'd2);
    chk("bp_b_ready", in_ready, 1'b0);
    chk("bp_b_alu", out_ALUResult[31:0], 32'hA);
    beat(32'hC, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    chk("bp_c_held_count", count, 2'd2);
    chk("bp_c_held_alu", out_ALUResult[31:0], 32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", out_ALUResult[31:0], 32'hB);
    chk("bp_out_b_count", count, 2'd1);
    chk("bp_out_b_ready", in_ready, 1'b1);
    tick();
    chk("bp_out_c", out_ALUResult[31:0], 32'hC);
    chk("bp_out_c_count", count, 2'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty_valid", out_valid, 1'b0);
    chk("bp_empty_count", count, 2'd0);

    // Kill and x0 suppression
    out_ready = 1'b0;
    beat(32'h80, 32'h81, 2'b11, 2'b01, 5'd3, 5'd0);
    tick();
    chk("kx_valid", out_valid, 1'b1);
    chk("kx_rw_both_off", out_RegWrite, 2'b00);
    out_ready = 1'b1;
    beat(32'h90, 32'h91, 2'b11, 2'b01, 5'd3, 5'd5);
    tick();
    chk("kx_rw_lane1", out_RegWrite, 2'b10);
    chk("kx_rd", out_Rd, 10'h0A3);
    in_valid = 1'b0;
    tick();
    chk("kx_rw_drained", out_RegWrite, 2'b00);

    // Flush with both entries full and a beat offered
    out_ready = 1'b0;
    beat(32'h41, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    beat(32'h42, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    chk("fl_full_count", count, 2'd2);
    beat(32'h43, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    flush = 1'b1;
    tick();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_count", count, 2'd0);
    chk("fl_ready", in_ready, 1'b1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_stays_empty", out_valid, 1'b0);
    // Flush in the same cycle as an accept
    out_ready = 1'b0;
    beat(32'h44, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    beat(32'h45, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    flush = 1'b1;
    tick();
    chk("fl2_count", count, 2'd0);
    chk("fl2_valid", out_valid, 1'b0);
    flush = 1'b0;
    out_ready = 1'b1;
    beat(32'h50, 32'h0, 2'b01, 2'b00, 5'd1, 5'd0);
    tick();
    chk("fl2_next_valid", out_valid, 1'b1);
    chk("fl2_next_alu", out_ALUResult[31:0], 32'h50);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset between edges
    out_ready = 1'b0;
    beat(32'h60, 32'h61, 2'b11, 2'b00, 5'd7, 5'd8);
    tick();
    chk("ar_loaded", out_valid, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_alu", out_ALUResult, 64'h0);
    chk("ar_rd", out_Rd, 10'h0);
    chk("ar_count", count, 2'd0);
    chk("ar_ready", in_ready, 1'b1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    beat(32'h70, 32'h71, 2'b11, 2'b00, 5'd7, 5'd8);
    tick();
    chk("ar_first_valid", out_valid, 1'b1);
    chk("ar_first_alu", out_ALUResult, 64'h0000_0071_0000_0070);
    in_valid = 1'b0;
    tick();

    // Four-lane, 64-bit build: unique pattern per lane
    for (int i = 0; i < 4; i++) begin
      in_ALUResult4[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      in_ReadData4[i*64 +: 64]  = ~(64'h1111_1111_1111_1111 * 64'(i + 1));
      in_Rd4[i*5 +: 5]          = 5'(i + 1);
    end
    in_RegWrite4 = 4'hF;
    in_valid4 = 1'b1;
    out_ready4 = 1'b1;
    tick();
    chk("w4_valid", out_valid4, 1'b1);
    chk("w4_lane0", out_ALUResult4[63:0], 64'h1111_1111_1111_1111);
    chk("w4_lane1", out_ALUResult4[127:64], 64'h2222_2222_2222_2222);
    chk("w4_lane2", out_ALUResult4[191:128], 64'h3333_3333_3333_3333);
    chk("w4_lane3", out_ALUResult4[255:192], 64'h4444_4444_4444_4444);
    chk("w4_rdata3", out_ReadData4[255:192], 64'hBBBB_BBBB_BBBB_BBBB);
    chk("w4_rw", out_RegWrite4, 4'hF);
    chk("w4_rd", out_Rd4, 20'h20C41);
    in_valid4 = 1'b0;
    tick();
    chk("w4_drained", count4, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_elastic.md
# mem_wb_pipe_elastic

Parametrised, elastic MEM→WB pipeline stage for the multi-issue core: carries LANES parallel writeback bundles from memory to writeback as one beat under a valid/ready handshake. A two-entry skid buffer (main + skid) lets writeback stall without a combinational ready path back into memory. The block also adds per-lane squash, suppression of x0 writes, and a synchronous flush.

## Interface
- LANES, 2, number of issue lanes per beat (≥1)
- XLEN, 32, datapath width
- REGW, 5, register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; discards all held beats
- in_valid  in  1  memory stage presents a beat
- in_ready  out  1  stage can accept a beat; registered
- in_kill  in  LANES  per-lane squash for the presented beat
- in_RegWrite  in  LANES  per-lane register write enable
- in_ResultSrc  in  2*LANES  per-lane result mux select; lane i at [2i+:2]
- in_ALUResult, in_ReadData, in_PCPlus4  in  XLEN*LANES  per-lane data; lane i at [i*XLEN+:XLEN]
- in_Rd  in  REGW*LANES  per-lane destination; lane i at [i*REGW+:REGW]
- out_valid  out  1  beat present at output
- out_ready  in  1  writeback consumes the beat
- out_RegWrite, out_ResultSrc, out_ALUResult, out_ReadData, out_PCPlus4, out_Rd  out  same widths as inputs  payload of the main entry
- count  out  2  occupancy, 0..2

## Operation
- Two entries: main (drives out_*) and skid. Each has a valid bit and a full payload.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- in_ready = !skid_valid, taken from a flop. out_valid = main_valid.
- Capture rule, lane i: stored RegWrite = in_RegWrite[i] & !in_kill[i] & (in_Rd[i] != 0). All other fields are stored unchanged.
- Transitions, keyed on {main_valid, skid_valid}:
  - {0,0}: Accept loads main.
  - {1,0}: Accept with Drain loads main from the input. Accept without Drain loads skid. Drain without Accept clears main.
  - {1,1}: Accept is impossible. Drain moves skid into main and clears skid.
  - {0,1}: unreachable. Verification asserts it never occurs.
- Order is strictly preserved: a beat in skid always leaves after the beat in main.
- out_RegWrite[i] = stored RegWrite[i] & out_valid, so an empty stage never writes the register file. Other out_* fields hold their last loaded value when the entry is invalid.
- count = main_valid + skid_valid.
- flush has priority over everything. On the next edge both valids clear and any beat accepted in the same cycle is dropped. Payload flops need not clear.
- rst_n low clears both valids and all payload flops immediately, without waiting for clk.

## Timing
- Reset values: out_valid=0, in_ready=1, count=0, every out_* payload bit=0.
- Latency is 1 cycle from an accepted beat to out_valid, provided the main entry was free or draining.
- Throughput is 1 beat/cycle sustained while out_ready=1. count then stays ≤1.
- With out_ready=0, the stage absorbs 2 beats. in_ready falls on the edge that fills skid.
- in_ready rises on the edge after the drain that empties skid. There is no combinational path from out_ready to in_ready.
- flush in cycle t gives out_valid=0, in_ready=1 and count=0 from t+1.
- Asserting rst_n mid-transfer loses all held beats. Deassertion is synchronised externally; the first accept is allowed on the first edge after release.

## Test plan
- Reset, then stream beats with out_ready=1 -> out_valid rises 1 cycle after each accept. Sequence ALUResult lane0 = 0x10, 0x20, 0x30 appears in order, one per cycle. count ≤1.
- Hold out_ready=0 and offer 3 beats A,B,C -> A and B accepted, in_ready=0 after B, C held by the source. Release out_ready -> outputs A, B, C in order with no duplicates or gaps.
- Kill and x0 suppression: in_RegWrite=2'b11, in_kill=2'b01, in_Rd lane1=0 -> out_RegWrite=2'b00. Send again with lane1 Rd=5 -> out_RegWrite=2'b10.
- Flush with count=2 and in_valid=1 in the same cycle -> next cycle out_valid=0, count=0, in_ready=1. The flushed beats and the same-cycle beat never appear.
- Async reset mid-stream: drop rst_n between clock edges -> outputs zero immediately. After release, the first new beat appears with latency 1.
- LANES=4, XLEN=64 build: a per-lane unique pattern (lane i ALUResult = 0x1111_1111_1111_1111·(i+1)) arrives at the correct lane slice.
